// File: rtl/mst_ft_pkg.sv
// Shared constants and payload types for the FT60x multi-channel master receive path.
package mst_ft_pkg;

  localparam int unsigned ADDRBIT            = 2;
  localparam int unsigned LENGTH             = 1 << ADDRBIT;
  localparam int unsigned WIDTH_DATA         = 32;
  localparam int unsigned WIDTH_BE           = 4;
  localparam int unsigned WIDTH_RX_DATA      = WIDTH_BE + WIDTH_DATA;
  localparam int unsigned CNT_CHANNLS        = 4;
  localparam int unsigned CNT_CODE_NUM_CHNLS = $clog2(CNT_CHANNLS);

  typedef struct packed {
    logic [WIDTH_BE-1:0]   be;
    logic [WIDTH_DATA-1:0] data;
  } rx_word_t;

  typedef logic [CNT_CODE_NUM_CHNLS-1:0] chn_idx_t;

endpackage

// File: rtl/mst_rx_chfifo.sv
// One LENGTH-deep per-channel receive buffer; writes to a full buffer are ignored.
module mst_rx_chfifo
  import mst_ft_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr,
  input  rx_word_t din,
  input  logic     rd,
  output rx_word_t head_c,
  output logic     full_c,
  output logic     empty_c
);

  logic [ADDRBIT-1:0] wr_ptr;
  logic [ADDRBIT-1:0] rd_ptr;
  logic [ADDRBIT:0]   len;
  rx_word_t           mem [LENGTH];
  logic               wr_en;
  logic               rd_en;

  assign full_c  = (len == (ADDRBIT+1)'(LENGTH));
  assign empty_c = (len == '0);
  assign wr_en   = wr && !full_c;
  assign rd_en   = rd && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Full is evaluated pre-pop, so a write to a full buffer is dropped even when popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      len    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDRBIT'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDRBIT'(1);
      case ({wr_en, rd_en})
        2'b10:   len <= len + (ADDRBIT+1)'(1);
        2'b01:   len <= len - (ADDRBIT+1)'(1);
        default: len <= len;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mst_rx_drain.sv
// Per-channel receive buffering with round-robin drain to the internal FIFO or stream checker.
// Define MST_RX_BE_MASK_EN to mask the streaming compare per byte by the word's byte-enables.
module mst_rx_drain
  import mst_ft_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx_wr,
  input  logic [CNT_CODE_NUM_CHNLS-1:0]     rx_chn,
  input  logic [WIDTH_RX_DATA-1:0]          rx_din,
  input  logic                              rx_mod,
  output logic [CNT_CHANNLS-1:0]            rx_nfull,
  output logic [CNT_CHANNLS-1:0]            rx_ovf,
  output logic                              i_fifo_wr,
  output logic [CNT_CODE_NUM_CHNLS-1:0]     i_fifo_chn,
  output logic [WIDTH_RX_DATA-1:0]          i_fifo_dat,
  input  logic [CNT_CHANNLS-1:0]            i_fifo_nfull,
  output logic [CNT_CHANNLS-1:0]            chk_req,
  input  logic [CNT_CHANNLS*WIDTH_DATA-1:0] chk_dat,
  output logic [CNT_CHANNLS-1:0]            chk_err,
  input  logic                              chk_clr
);

  logic [CNT_CHANNLS-1:0] full_c;
  logic [CNT_CHANNLS-1:0] empty_c;
  logic [CNT_CHANNLS-1:0] drainable_c;
  logic [CNT_CHANNLS-1:0] pop_c;
  logic [CNT_CHANNLS-1:0] ovf_set_c;
  logic [CNT_CHANNLS-1:0] err_set_c;
  rx_word_t               head_c [CNT_CHANNLS];
  rx_word_t               sel_word_c;
  logic [WIDTH_DATA-1:0]  exp_c;
  logic [WIDTH_DATA-1:0]  cmp_mask_c;
  logic                   mismatch_c;
  logic                   pop_vld_c;
  chn_idx_t               sel_c;
  chn_idx_t               idx_c;
  chn_idx_t               rr_ptr;

  for (genvar g = 0; g < CNT_CHANNLS; g++) begin : g_chn
    mst_rx_chfifo u_chfifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (rx_wr && (rx_chn == chn_idx_t'(g))),
      .din     (rx_word_t'(rx_din)),
      .rd      (pop_c[g]),
      .head_c  (head_c[g]),
      .full_c  (full_c[g]),
      .empty_c (empty_c[g])
    );
    assign drainable_c[g] = !empty_c[g] && (rx_mod || i_fifo_nfull[g]);
  end

  assign rx_nfull = ~full_c;

  // Circular search for the first drainable channel at or after rr_ptr
  always_comb begin
    pop_vld_c = 1'b0;
    sel_c     = rr_ptr;
    idx_c     = rr_ptr;
    for (int i = 0; i < CNT_CHANNLS; i++) begin
      idx_c = rr_ptr + chn_idx_t'(i);
      if (!pop_vld_c && drainable_c[idx_c]) begin
        pop_vld_c = 1'b1;
        sel_c     = idx_c;
      end
    end
  end

  assign pop_c      = pop_vld_c ? (CNT_CHANNLS'(1) << sel_c) : '0;
  assign chk_req    = rx_mod ? pop_c : '0;
  assign sel_word_c = head_c[sel_c];

  always_comb begin
    exp_c = '0;
    for (int n = 0; n < CNT_CHANNLS; n++) begin
      if (sel_c == chn_idx_t'(n)) exp_c = chk_dat[n*WIDTH_DATA +: WIDTH_DATA];
    end
  end

`ifdef MST_RX_BE_MASK_EN
  always_comb begin
    cmp_mask_c = '0;
    for (int k = 0; k < WIDTH_BE; k++) begin
      cmp_mask_c[k*8 +: 8] = {8{sel_word_c.be[k]}};
    end
  end
`else
  assign cmp_mask_c = '1;
`endif

  assign mismatch_c = |((sel_word_c.data ^ exp_c) & cmp_mask_c);
  assign err_set_c  = (rx_mod && mismatch_c) ? pop_c : '0;
  assign ovf_set_c  = (rx_wr && full_c[rx_chn]) ? (CNT_CHANNLS'(1) << rx_chn) : '0;

  // Arbiter pointer, loop-back output register and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      i_fifo_wr  <= 1'b0;
      i_fifo_chn <= '0;
      i_fifo_dat <= '0;
      rx_ovf     <= '0;
      chk_err    <= '0;
    end else begin
      if (pop_vld_c) rr_ptr <= sel_c + chn_idx_t'(1);
      i_fifo_wr <= pop_vld_c && !rx_mod;
      if (pop_vld_c && !rx_mod) begin
        i_fifo_chn <= sel_c;
        i_fifo_dat <= sel_word_c;
      end
      rx_ovf  <= (chk_clr ? '0 : rx_ovf)  | ovf_set_c;
      chk_err <= (chk_clr ? '0 : chk_err) | err_set_c;
    end
  end

endmodule
